// File: rtl/oam_dma_ctrl_if.sv
// CPU-bus view of the OAM DMA controller: CPU cycle strobe/address/data in, DMA bus drive out.
// Pure signal grouping, no timing of its own.
interface oam_dma_ctrl_if;
  logic        cpu_ce_i;
  logic [15:0] cpu_a_i;
  logic [7:0]  cpu_d_i;
  logic        cpu_rw_i;
  logic [7:0]  bus_d_i;
  logic        cpu_halt_o;
  logic        dma_active_o;
  logic [15:0] dma_a_o;
  logic [7:0]  dma_d_o;
  logic        dma_rw_o;
  logic        dma_done_o;

  modport master (
    output cpu_ce_i, cpu_a_i, cpu_d_i, cpu_rw_i, bus_d_i,
    input  cpu_halt_o, dma_active_o, dma_a_o, dma_d_o, dma_rw_o, dma_done_o
  );

  modport slave (
    input  cpu_ce_i, cpu_a_i, cpu_d_i, cpu_rw_i, bus_d_i,
    output cpu_halt_o, dma_active_o, dma_a_o, dma_d_o, dma_rw_o, dma_done_o
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: a CPU write to REG_ADDR halts the CPU and copies one 256-byte page to OAM_ADDR.
// Advances one step per cpu_ce_i strobe, outputs registered; 514/515 halted CPU cycles, no backpressure.
module oam_dma_ctrl #(
  parameter logic [15:0] REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR = 16'h2004
) (
  input  logic          clk,
  input  logic          rst,
  oam_dma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        p_q, p_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        halt_q, halt_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [15:0] dma_a_q, dma_a_d;
  logic [7:0]  dma_d_q, dma_d_d;
  logic        dma_rw_q, dma_rw_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p_q      <= 1'b0;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      halt_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      dma_a_q  <= 16'h0000;
      dma_d_q  <= 8'h00;
      dma_rw_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      halt_q   <= halt_d;
      active_q <= active_d;
      done_q   <= done_d;
      dma_a_q  <= dma_a_d;
      dma_d_q  <= dma_d_d;
      dma_rw_q <= dma_rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if (bus.cpu_ce_i) begin
      p_d = ~p_q;
      case (state_q)
        ST_IDLE: begin
          if (bus.cpu_a_i == REG_ADDR && !bus.cpu_rw_i) begin
            page_d  = bus.cpu_d_i;
            idx_d   = 8'h00;
            state_d = ST_HALT;
          end
        end
        // The CPU only honours RDY on a read cycle, so wait for one.
        ST_HALT: begin
          if (bus.cpu_rw_i) state_d = ST_ALIGN;
        end
        // Reads must land on get (p=0) cycles; leave ALIGN only from a put cycle.
        ST_ALIGN: begin
          if (p_q) state_d = ST_READ;
        end
        ST_READ: begin
          data_d  = bus.bus_d_i;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet track the state.
  always_comb begin
    halt_d   = (state_d != ST_IDLE);
    active_d = (state_d == ST_ALIGN) || (state_d == ST_READ) || (state_d == ST_WRITE);
    dma_a_d  = 16'h0000;
    dma_d_d  = 8'h00;
    dma_rw_d = 1'b1;
    case (state_d)
      ST_READ: begin
        dma_a_d = {page_d, idx_d};
      end
      ST_WRITE: begin
        dma_a_d  = OAM_ADDR;
        dma_d_d  = data_d;
        dma_rw_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.cpu_halt_o   = halt_q;
  assign bus.dma_active_o = active_q;
  assign bus.dma_done_o   = done_q;
  assign bus.dma_a_o      = dma_a_q;
  assign bus.dma_d_o      = dma_d_q;
  assign bus.dma_rw_o     = dma_rw_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus pushes expected DMA bus cycles, a negedge monitor pops and compares.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_ctrl_if ifc();

  oam_dma_ctrl #(
    .REG_ADDR(16'h4014),
    .OAM_ADDR(16'h2004)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // Memory model: the byte at {page, idx} is idx ^ page ^ 5A.
  assign ifc.bus_d_i = ifc.dma_a_o[7:0] ^ ifc.dma_a_o[15:8] ^ 8'h5A;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
  } bus_txn_t;

  bus_txn_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int halt_cnt = 0;
  bit p_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one bus cycle per committed CPU cycle; ALIGN (active, read, address 0) is not a bus cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.cpu_ce_i) begin
        if (ifc.cpu_halt_o) halt_cnt++;
        if (ifc.dma_active_o && !(ifc.dma_rw_o && ifc.dma_a_o == 16'h0000)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_cycle: got a=%0h rw=%0b, expected none", ifc.dma_a_o, ifc.dma_rw_o);
          end else begin
            bus_txn_t t;
            t = exp_q.pop_front();
            check("dma_addr", ifc.dma_a_o, t.a);
            check("dma_rw", ifc.dma_rw_o, t.rw);
            if (!t.rw) begin
              check("dma_wdata", ifc.dma_d_o, t.d);
              wr_cnt++;
            end
          end
        end
      end
      if (ifc.dma_done_o) begin
        done_cnt++;
        check("halt_low_at_done", ifc.cpu_halt_o, 0);
      end
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    ifc.cpu_a_i  = a;
    ifc.cpu_d_i  = d;
    ifc.cpu_rw_i = rw;
    ifc.cpu_ce_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifc.cpu_ce_i = 1'b1;
    @(posedge clk); #1;
    ifc.cpu_ce_i = 1'b0;
    p_model = ~p_model;
  endtask

  task automatic push_transfer(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = i[7:0];
      exp_q.push_back('{a: {page, idx}, d: 8'h00, rw: 1'b1});
      exp_q.push_back('{a: 16'h2004, d: idx ^ page ^ 8'h5A, rw: 1'b0});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_halt"}, ifc.cpu_halt_o, 0);
    check({tag, "_active"}, ifc.dma_active_o, 0);
    check({tag, "_dma_a"}, ifc.dma_a_o, 16'h0000);
    check({tag, "_dma_d"}, ifc.dma_d_o, 8'h00);
    check({tag, "_dma_rw"}, ifc.dma_rw_o, 1);
    check({tag, "_done"}, ifc.dma_done_o, 0);
  endtask

  task automatic set_parity(input bit want);
    if (p_model != want) cpu_cycle(16'h0000, 8'h00, 1'b1);
  endtask

  // Trigger, optional CPU writes while in HALT (to REG_ADDR, must be ignored), then stalled reads.
  task automatic run_transfer(input logic [7:0] page, input int n_halt_wr, input bit mid_write);
    bit t;
    bit align_p;
    int exp_halt;
    int done_base;
    int budget;
    t = p_model;
    align_p = t ^ n_halt_wr[0];
    exp_halt = (n_halt_wr + 1) + (align_p ? 1 : 2) + 512;
    done_base = done_cnt;
    halt_cnt = 0;
    push_transfer(page);
    cpu_cycle(16'h4014, page, 1'b0);
    check("halt_after_trigger", ifc.cpu_halt_o, 1);
    check("inactive_in_halt", ifc.dma_active_o, 0);
    for (int k = 0; k < n_halt_wr; k++) begin
      cpu_cycle(16'h4014, 8'h07, 1'b0);
      check("stay_halt_on_write", ifc.cpu_halt_o, 1);
      check("stay_inactive_on_write", ifc.dma_active_o, 0);
    end
    budget = 0;
    while (done_cnt == done_base && budget < 700) begin
      if (mid_write && budget == 60) cpu_cycle(16'h4014, 8'h07, 1'b0);
      else cpu_cycle(16'h8000, 8'h00, 1'b1);
      budget++;
    end
    check("done_pulses", done_cnt - done_base, 1);
    check("halt_cycles", halt_cnt, exp_halt);
    check("queue_drained", exp_q.size(), 0);
    check_idle_outputs("post_transfer");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    int wr_base;
    int done_base;
    rst = 1'b1;
    ifc.cpu_ce_i = 1'b0;
    ifc.cpu_a_i  = 16'h0000;
    ifc.cpu_d_i  = 8'h00;
    ifc.cpu_rw_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    p_model = 1'b0;

    // Single ALIGN cycle: 514 halted cycles.
    set_parity(1'b1);
    run_transfer(8'h02, 0, 1'b0);

    // Parity shifted: two ALIGN cycles, 515 halted cycles.
    set_parity(1'b0);
    run_transfer(8'h02, 0, 1'b0);

    // CPU keeps writing (to REG_ADDR) in HALT, and again mid-transfer: page stays 02.
    run_transfer(8'h02, 2, 1'b1);

    // Reset after the 100th write abandons the transfer silently.
    push_transfer(8'h02);
    wr_base = wr_cnt;
    done_base = done_cnt;
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    budget = 0;
    while (wr_cnt - wr_base < 100 && budget < 400) begin
      cpu_cycle(16'h8000, 8'h00, 1'b1);
      budget++;
    end
    check("writes_before_reset", wr_cnt - wr_base, 100);
    check("busy_before_reset", ifc.dma_active_o, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("remaining_after_reset", exp_q.size(), 312);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("no_done_on_reset", done_cnt - done_base, 0);
    rst = 1'b0;
    p_model = 1'b0;
    run_transfer(8'h03, 0, 1'b0);

    // Read of REG_ADDR and write to REG_ADDR+1 trigger nothing.
    done_base = done_cnt;
    cpu_cycle(16'h4014, 8'h09, 1'b1);
    check("read_reg_no_halt", ifc.cpu_halt_o, 0);
    cpu_cycle(16'h4015, 8'h09, 1'b0);
    check("wr_4015_no_halt", ifc.cpu_halt_o, 0);
    repeat (4) cpu_cycle(16'h8000, 8'h00, 1'b1);
    check_idle_outputs("no_trigger");
    check("no_trigger_done", done_cnt - done_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
